// File: rtl/alu_func_encoder.sv
// Decode stage: MIPS instruction word -> ALU function code and operand flags, with a
// 2-entry skid buffer. Optional perf counters under ALU_FUNC_ENCODER_PERF_EN.
module alu_func_encoder #(
  parameter logic [5:0] NONE_DEFAULT_FUNC = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [5:0]  out_func,
  output logic        out_use_imm,
  output logic        out_imm_zext,
  output logic        out_illegal
`ifdef ALU_FUNC_ENCODER_PERF_EN
  ,
  output logic [31:0] perf_decoded,
  output logic [31:0] perf_illegal
`endif
);

  localparam int unsigned EntryW = 41;

  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;
  logic [5:0] dec_func;
  logic       dec_use_imm;
  logic       dec_imm_zext;
  logic       dec_illegal;

  assign op    = in_instr[31:26];
  assign rt    = in_instr[20:16];
  assign funct = in_instr[5:0];

  always_comb begin
    dec_func     = NONE_DEFAULT_FUNC;
    dec_use_imm  = 1'b0;
    dec_imm_zext = 1'b0;
    dec_illegal  = 1'b0;
    case (op)
      6'b000000: begin
        if (in_instr == 32'd0) begin
          dec_func = NONE_DEFAULT_FUNC;
        end else if (funct[5:3] == 3'b100 || funct == 6'b101010 || funct == 6'b101011) begin
          dec_func = funct;
        end else if (funct == 6'b001000 || funct == 6'b001001) begin
          dec_func = 6'b111011;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'b000001: begin
        if (rt == 5'd0) begin
          dec_func = 6'b111000;
        end else if (rt == 5'd1) begin
          dec_func = 6'b111001;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'b000010, 6'b000011: dec_func = 6'b111010;
      // Branch funcs 1111xx track the low opcode bits directly.
      6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_func = {4'b1111, op[1:0]};
      6'b001000: begin dec_func = 6'b100000; dec_use_imm = 1'b1; end
      6'b001001: begin dec_func = 6'b100001; dec_use_imm = 1'b1; end
      6'b001010: begin dec_func = 6'b101010; dec_use_imm = 1'b1; end
      6'b001011: begin dec_func = 6'b101011; dec_use_imm = 1'b1; end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_func     = {3'b100, op[2:0]};
        dec_use_imm  = 1'b1;
        dec_imm_zext = 1'b1;
      end
      6'b001111: begin dec_use_imm = 1'b1; dec_imm_zext = 1'b1; end
      6'b100000, 6'b100001, 6'b100011, 6'b100100,
      6'b100101, 6'b101000, 6'b101001, 6'b101011: begin
        dec_func    = 6'b100001;
        dec_use_imm = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic [EntryW-1:0] in_entry;
  logic [EntryW-1:0] main_q, main_d, skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, drain;

  assign in_entry = {in_instr, dec_func, dec_use_imm, dec_imm_zext, dec_illegal};
  assign accept   = in_valid && in_ready_q;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // A full skid slot implies in_ready is low, so no accept can coincide here.
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_entry;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_entry;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign {out_instr, out_func, out_use_imm, out_imm_zext, out_illegal} = main_q;

`ifdef ALU_FUNC_ENCODER_PERF_EN
  logic [31:0] perf_decoded_q, perf_illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_decoded_q <= '0;
      perf_illegal_q <= '0;
    end else if (drain) begin
      perf_decoded_q <= perf_decoded_q + 32'd1;
      if (out_illegal) perf_illegal_q <= perf_illegal_q + 32'd1;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_func_encoder.sv
// Bench for alu_func_encoder: directed steps plus random traffic against a queue-based
// reference model; perf counters checked when ALU_FUNC_ENCODER_PERF_EN is defined.
module tb_alu_func_encoder;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic        out_use_imm, out_imm_zext, out_illegal;
  logic [31:0] in_instr, out_instr;
  logic [5:0]  out_func;
`ifdef ALU_FUNC_ENCODER_PERF_EN
  logic [31:0] perf_decoded, perf_illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_func_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_func     (out_func),
    .out_use_imm  (out_use_imm),
    .out_imm_zext (out_imm_zext),
    .out_illegal  (out_illegal)
`ifdef ALU_FUNC_ENCODER_PERF_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  func;
    logic        use_imm;
    logic        zext;
    logic        illegal;
  } exp_t;

  exp_t        q[$];
  logic        m_in_ready;
  int unsigned m_perf_dec, m_perf_ill;

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   op, fn, rt;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    rt = int'(w[20:16]);
    e.instr = w; e.func = 6'd0; e.use_imm = 1'b0; e.zext = 1'b0; e.illegal = 1'b0;
    if (w == 32'd0) return e;
    if (op == 0) begin
      if ((fn >= 32 && fn <= 39) || fn == 42 || fn == 43) e.func = 6'(fn);
      else if (fn == 8 || fn == 9) e.func = 6'd59;
      else e.illegal = 1'b1;
    end else if (op == 1) begin
      if (rt == 0) e.func = 6'd56;
      else if (rt == 1) e.func = 6'd57;
      else e.illegal = 1'b1;
    end else if (op == 2 || op == 3) begin
      e.func = 6'd58;
    end else if (op >= 4 && op <= 7) begin
      e.func = 6'(56 + op);
    end else if (op >= 8 && op <= 11) begin
      e.use_imm = 1'b1;
      case (op)
        8:       e.func = 6'd32;
        9:       e.func = 6'd33;
        10:      e.func = 6'd42;
        default: e.func = 6'd43;
      endcase
    end else if (op >= 12 && op <= 14) begin
      e.func = 6'(op + 24); e.use_imm = 1'b1; e.zext = 1'b1;
    end else if (op == 15) begin
      e.use_imm = 1'b1; e.zext = 1'b1;
    end else if (op inside {32, 33, 35, 36, 37, 40, 41, 43}) begin
      e.func = 6'd33; e.use_imm = 1'b1;
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: begin
        w[31:26] = 6'd0;
        w[5:0]   = 6'($urandom_range(0, 47));
      end
      1: w[31:26] = 6'($urandom_range(0, 15));
      2: begin
        w[31:26] = 6'd1;
        w[20:16] = 5'($urandom_range(0, 2));
      end
      3: w[31:26] = 6'($urandom_range(32, 47));
      4: w = 32'd0;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare at the falling edge, then advance one rising edge and update the model.
  task automatic tick();
    logic accept, drain;
    chk("in_ready", 32'(in_ready), 32'(m_in_ready));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_func", 32'(out_func), 32'(q[0].func));
      chk("out_use_imm", 32'(out_use_imm), 32'(q[0].use_imm));
      chk("out_imm_zext", 32'(out_imm_zext), 32'(q[0].zext));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].illegal));
    end
`ifdef ALU_FUNC_ENCODER_PERF_EN
    chk("perf_decoded", perf_decoded, m_perf_dec);
    chk("perf_illegal", perf_illegal, m_perf_ill);
`endif
    accept = in_valid && m_in_ready;
    drain  = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_in_ready = 1'b1;
      m_perf_dec = 0;
      m_perf_ill = 0;
    end else begin
      if (drain) begin
        m_perf_dec++;
        if (q[0].illegal) m_perf_ill++;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (accept) q.push_back(ref_decode(in_instr));
      m_in_ready = q.size() < 2;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] seq3 [3];
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    m_in_ready = 1'b1; m_perf_dec = 0; m_perf_ill = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_func", 32'(out_func), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_flags", 32'({out_use_imm, out_imm_zext, out_illegal}), 32'd0);

    // ADDU, one-cycle latency
    in_valid = 1'b1; in_instr = 32'h0022_1821; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addu_valid", 32'(out_valid), 32'd1);
    chk("addu_func", 32'(out_func), 32'b100001);
    chk("addu_imm", 32'(out_use_imm), 32'd0);
    chk("addu_ill", 32'(out_illegal), 32'd0);
    tick();

    // ORI then LW back to back
    in_valid = 1'b1; in_instr = 32'h3422_0005;
    tick();
    chk("ori_func", 32'(out_func), 32'b100101);
    chk("ori_flags", 32'({out_use_imm, out_imm_zext}), 32'b11);
    in_instr = 32'h8C22_0004;
    tick();
    in_valid = 1'b0;
    chk("lw_func", 32'(out_func), 32'b100001);
    chk("lw_flags", 32'({out_use_imm, out_imm_zext}), 32'b10);
    tick();

    // BGEZ, JR, J in order
    seq3[0] = 32'h0421_0003; seq3[1] = 32'h03E0_0008; seq3[2] = 32'h0800_0010;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = seq3[i];
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // Back-pressure fills main and skid; third waits for in_ready
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0022_1821; tick();
    in_instr = 32'h3422_0005; tick();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_instr = 32'h0800_0010;
    repeat (2) tick();
    out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Flush with two buffered and an offer in the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0421_0003; tick();
    in_instr = 32'h03E0_0008; tick();
    flush = 1'b1; in_instr = 32'h8C22_0004;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Illegal encodings and NOP after a reset
    reset = 1'b1; tick(); reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'h4000_0000; tick();
    chk("cop0_ill", 32'(out_illegal), 32'd1);
    chk("cop0_func", 32'(out_func), 32'd0);
    in_instr = 32'h0001_1080; tick();
    chk("sll_ill", 32'(out_illegal), 32'd1);
    chk("sll_func", 32'(out_func), 32'd0);
    in_instr = 32'h0000_0000; tick();
    chk("nop_ill", 32'(out_illegal), 32'd0);
    chk("nop_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
`ifdef ALU_FUNC_ENCODER_PERF_EN
    chk("perf_dec_3", perf_decoded, 32'd3);
    chk("perf_ill_2", perf_illegal, 32'd2);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      in_instr  = gen_instr();
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_func_encoder.md
Name: alu_func_encoder

Overview:
- Decode-stage block that turns a 32-bit MIPS instruction word into the 6-bit ALU function code that the single-cycle ALU consumes, plus operand-select flags.
- Registered stage with valid/ready handshake on both sides.
- A 2-entry skid buffer keeps `in_ready` driven straight from a flop.
- Sits between instruction fetch and the ALU/register-read logic.

Parameters:
- NONE_DEFAULT_FUNC, 6'b000000, Func emitted for NOP and illegal instructions (ALU passes B).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of all buffered entries.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  32  instruction word.
- `out_valid`  out  1  decoded entry present.
- `out_ready`  in  1  consumer accepts.
- `out_instr`  out  32  instruction word passed through unchanged.
- `out_func`  out  6  ALU function code.
- `out_use_imm`  out  1  B operand is the immediate.
- `out_imm_zext`  out  1  immediate is zero-extended; 0 = sign-extended.
- `out_illegal`  out  1  unsupported encoding.

Behaviour:
- Reset values:
  - `out_valid` = 0, `in_ready` = 1, `out_func` = 0, `out_use_imm` = 0, `out_imm_zext` = 0, `out_illegal` = 0, `out_instr` = 0.
  - Skid buffer empty.
- Decode is combinational on `in_instr` and is captured at accept. Field names: op = [31:26], rt = [20:16], funct = [5:0].
- op 000000 (R-type):
  - funct 100000..100111, 101010, 101011 → func = funct.
  - funct 001000 (JR) or 001001 (JALR) → 111011.
  - Instruction word 0x00000000 (NOP) → NONE_DEFAULT_FUNC, not illegal.
  - Any other funct, including nonzero shifts → illegal.
- op 000001: rt 00000 → 111000 (BLTZ); rt 00001 → 111001 (BGEZ); any other rt → illegal.
- Jumps: op 000010 or 000011 → 111010.
- Branches: op 000100 → 111100, 000101 → 111101, 000110 → 111110, 000111 → 111111.
- Immediate ALU ops:
  - op 001000 → 100000; op 001001 → 100001.
  - op 001010 → 101010; op 001011 → 101011.
  - All four set use_imm = 1, imm_zext = 0.
- Logical immediates: op 001100 → 100100, 001101 → 100101, 001110 → 100110; all set use_imm = 1, imm_zext = 1.
- op 001111 (LUI) → NONE_DEFAULT_FUNC, use_imm = 1, imm_zext = 1.
- Loads and stores: op 100000, 100001, 100011, 100100, 100101, 101000, 101001, 101011 → 100001, use_imm = 1, imm_zext = 0.
- Everything else → illegal = 1, func = NONE_DEFAULT_FUNC, use_imm = 0, imm_zext = 0.
- Illegal entries still flow through the pipeline in order with `out_valid` = 1.
- Handshake:
  - Accept when `in_valid` && `in_ready`.
  - Output transfer when `out_valid` && `out_ready`.
  - Output fields are stable while `out_valid` && !`out_ready`.
- Latency: empty stage → accepted entry appears on `out_valid` the next cycle.
- Throughput: 1 per cycle while `out_ready` = 1.
- Buffer rules:
  - If the main entry is stalled and an accept occurs, the new entry goes to the skid slot.
  - `in_ready` next = skid slot empty after this cycle's updates.
  - When main drains with skid full, skid moves to main the same edge.
  - Ordering is strictly FIFO.
- Simultaneous accept and drain with the main slot full and skid empty: new entry replaces main, no bubble.
- `flush`:
  - Next cycle `out_valid` = 0, skid empty, `in_ready` = 1.
  - An accept in the flush cycle is discarded.
  - Output data regs are not cleared.
- `reset` mid-operation overrides `flush` and all handshakes; state returns to reset values next edge.

Optional Feature:
- Macro: ALU_FUNC_ENCODER_PERF_EN.
- Defined:
  - Adds output `perf_decoded` (32) counting output transfers and output `perf_illegal` (32) counting transfers with `out_illegal` = 1.
  - Both counters wrap modulo 2^32, are cleared by `reset`, and are not affected by `flush`.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then `in_instr` = 0x00221821 (ADDU), `out_ready` = 1 → next cycle `out_valid` = 1, func = 6'b100001, use_imm = 0, illegal = 0.
2. Send 0x34220005 (ORI) then 0x8C220004 (LW) back-to-back → func 100101 with use_imm = 1, imm_zext = 1; then func 100001 with use_imm = 1, imm_zext = 0; one cycle apart.
3. Send 0x04210003 (BGEZ), 0x03E00008 (JR), 0x08000010 (J) → funcs 111001, 111011, 111010 in order.
4. Hold `out_ready` = 0 and offer 3 instructions → first two accepted, `in_ready` = 0 the cycle after the second. Release `out_ready` → entries drain in order, and the third is accepted only after `in_ready` returns to 1.
5. Two entries buffered, assert `flush` together with `in_valid` → next cycle `out_valid` = 0, `in_ready` = 1, and no entry from the flush cycle ever appears.
6. Send 0x40000000 (COP0) and 0x00011080 (SLL, nonzero) → both give `out_illegal` = 1, func = 000000. Send 0x00000000 → illegal = 0. With ALU_FUNC_ENCODER_PERF_EN: `perf_decoded` = 3, `perf_illegal` = 2.
